// File: rtl/pw_lock_ctrl.sv
// pw_lock_ctrl -- password lock controller with retry limit and timed lockout.
//
// Compares a 16-bit guess against the stored password on each rising edge of
// `check`. Too many consecutive mismatches send the lock into a timed lockout,
// and `lock` re-arms an open or unlocked controller.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   guess_pw    16-bit guess
//   actual_pw   16-bit stored password
//   check       level input; a rising edge requests a comparison
//   lock        level input; a rising edge requests arm/re-lock
//   state       FSM state: OPEN=00, LOCKED=01, UNLOCKED=10, LOCKOUT=11
//   unlocked    high in OPEN or UNLOCKED
//   lockout     high in LOCKOUT
//   pass_pulse  one-cycle pulse on a matching guess
//   fail_pulse  one-cycle pulse on a mismatching guess
//   tries_left  MAX_TRIES minus the current consecutive failures
module pw_lock_ctrl #(
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] guess_pw,
    input  logic [15:0] actual_pw,
    input  logic        check,
    input  logic        lock,
    output logic [1:0]  state,
    output logic        unlocked,
    output logic        lockout,
    output logic        pass_pulse,
    output logic        fail_pulse,
    output logic [1:0]  tries_left
);

    // The counter only has to hold LOCKOUT_CYCLES-1, so clog2 bits suffice.
    localparam int CNT_W = (LOCKOUT_CYCLES > 2) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]       MAX_CNT  = 2'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_OPEN     = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_UNLOCKED = 2'b10,
        ST_LOCKOUT  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              check_q, lock_q;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;

    logic              check_rise, lock_rise;
    logic [2:0]        fail_next;

    assign check_rise = check & ~check_q;
    assign lock_rise  = lock & ~lock_q;
    // One bit wider so the compare against MAX_CNT cannot wrap.
    assign fail_next  = {1'b0, fail_cnt_q} + 3'd1;

    always_comb begin
        state_d    = state_q;
        fail_cnt_d = fail_cnt_q;
        cnt_d      = cnt_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        unique case (state_q)
            ST_OPEN: begin
                if (lock_rise) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                // A simultaneous lock edge has no meaning here; only check acts.
                if (check_rise) begin
                    if (guess_pw == actual_pw) begin
                        state_d    = ST_UNLOCKED;
                        fail_cnt_d = 2'd0;
                        pass_d     = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        if (fail_cnt_q < MAX_CNT) fail_cnt_d = fail_next[1:0];
                        if (fail_next >= {1'b0, MAX_CNT}) begin
                            state_d = ST_LOCKOUT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
            end
            ST_UNLOCKED: begin
                // Re-locking takes priority over any concurrent check.
                if (lock_rise) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = 2'd0;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = 2'd0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            fail_cnt_q <= 2'd0;
            cnt_q      <= '0;
            check_q    <= 1'b0;
            lock_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_cnt_q <= fail_cnt_d;
            cnt_q      <= cnt_d;
            check_q    <= check;
            lock_q     <= lock;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

    assign state      = state_q;
    assign unlocked   = (state_q == ST_OPEN) || (state_q == ST_UNLOCKED);
    assign lockout    = (state_q == ST_LOCKOUT);
    assign pass_pulse = pass_q;
    assign fail_pulse = fail_q;
    assign tries_left = MAX_CNT - fail_cnt_q;

endmodule

// File: tb/tb_pw_lock_ctrl.sv
// Bench for pw_lock_ctrl: directed scenarios plus random traffic, with a
// behavioural model feeding an expected-output queue drained by a monitor.
module tb_pw_lock_ctrl;
    localparam int MAX_TRIES      = 3;
    localparam int LOCKOUT_CYCLES = 8;
    localparam int W = 8; // {state[1:0], unlocked, lockout, pass, fail, tries[1:0]}
    localparam logic [W-1:0] RESET_EXP = 8'b00_1_0_0_0_11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] guess_pw = 16'h0;
    logic [15:0] actual_pw = 16'h0;
    logic        check = 1'b0;
    logic        lock = 1'b0;
    logic [1:0]  state;
    logic        unlocked, lockout, pass_pulse, fail_pulse;
    logic [1:0]  tries_left;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state: mode 0=open 1=locked 2=unlocked 3=lockout.
    int m_mode, m_fails, m_remaining;
    bit m_prev_check, m_prev_lock, m_pass, m_fail;

    pw_lock_ctrl #(.MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)) dut (
        .clk(clk), .reset(reset), .guess_pw(guess_pw), .actual_pw(actual_pw),
        .check(check), .lock(lock), .state(state), .unlocked(unlocked),
        .lockout(lockout), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .tries_left(tries_left)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dut_vec();
        return {state, unlocked, lockout, pass_pulse, fail_pulse, tries_left};
    endfunction

    function automatic logic [W-1:0] model_vec();
        logic [1:0] st, tl;
        st = 2'(m_mode);
        tl = 2'(MAX_TRIES - m_fails);
        return {st, (m_mode == 0 || m_mode == 2), (m_mode == 3), m_pass, m_fail, tl};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fails = 0; m_remaining = 0;
        m_prev_check = 0; m_prev_lock = 0; m_pass = 0; m_fail = 0;
    endtask

    // One clock edge of behaviour, straight from the rules of the lock.
    task automatic model_step(input bit lk, input bit ck, input logic [15:0] g, input logic [15:0] a);
        bit cr, lr;
        cr = ck && !m_prev_check;
        lr = lk && !m_prev_lock;
        m_prev_check = ck;
        m_prev_lock = lk;
        m_pass = 0;
        m_fail = 0;
        if (m_mode == 0) begin
            if (lr) m_mode = 1;
        end else if (m_mode == 1) begin
            if (cr && g == a) begin
                m_mode = 2; m_fails = 0; m_pass = 1;
            end else if (cr) begin
                m_fail = 1;
                if (m_fails < MAX_TRIES) m_fails++;
                if (m_fails == MAX_TRIES) begin
                    m_mode = 3;
                    m_remaining = LOCKOUT_CYCLES;
                end
            end
        end else if (m_mode == 2) begin
            if (lr) begin m_mode = 1; m_fails = 0; end
        end else begin
            m_remaining--;
            if (m_remaining == 0) begin m_mode = 1; m_fails = 0; end
        end
    endtask

    task automatic apply(input bit lk, input bit ck, input logic [15:0] g, input logic [15:0] a);
        lock = lk; check = ck; guess_pw = g; actual_pw = a;
        model_step(lk, ck, g, a);
        exp_q.push_back(model_vec());
    endtask

    task automatic cyc(input bit lk, input bit ck, input logic [15:0] g, input logic [15:0] a);
        @(negedge clk);
        apply(lk, ck, g, a);
    endtask

    task automatic check_now(input string name, input logic [W-1:0] exp);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", name, dut_vec(), exp, $time);
        end
    endtask

    // Reset in the middle of a cycle; outputs must change with no clock edge.
    // Lock is held high across release so the first edge sees it as a rise.
    task automatic mid_reset(input string name);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_now(name, RESET_EXP);
        model_reset();
        lock = 1'b1; check = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply(1, 0, 16'h0, 16'h0);
    endtask

    // Monitor: each post-edge sample is matched against the next expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && exp_q.size() > 0) check_now("outputs", exp_q.pop_front());
        end
    end

    initial begin
        logic [15:0] a, g;
        bit ck, lk;
        model_reset();
        #3;
        check_now("reset_values", RESET_EXP);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        apply(0, 0, 16'h0, 16'h0);

        // Arm, then correct guess.
        cyc(1, 0, 16'h0000, 16'h0000);
        cyc(0, 0, 16'h0000, 16'h0000);
        cyc(0, 1, 16'h0000, 16'h0000);
        cyc(0, 0, 16'h0000, 16'h0000);
        // Re-lock, three wrong guesses, lockout with ignored checks.
        cyc(1, 0, 16'hFFFF, 16'h0000);
        cyc(0, 0, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 16'hFFFF, 16'h0000);
            cyc(0, 0, 16'hFFFF, 16'h0000);
        end
        for (int i = 0; i < 10; i++) cyc(i % 3 == 0, i % 2 == 0, 16'h0000, 16'h0000);
        cyc(0, 0, 16'hAAAA, 16'h0000);
        // Two misses then a hit restores the full try count.
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 16'hAAAA, 16'h0000);
            cyc(0, 0, 16'hAAAA, 16'h0000);
        end
        cyc(0, 1, 16'h0000, 16'h0000);
        cyc(0, 0, 16'h0000, 16'h0000);
        // Held check gives one comparison only.
        cyc(1, 0, 16'hFFFF, 16'h0000);
        cyc(0, 0, 16'hFFFF, 16'h0000);
        for (int i = 0; i < 20; i++) cyc(0, 1, 16'hFFFF, 16'h0000);
        cyc(0, 0, 16'h1234, 16'h1234);
        cyc(0, 1, 16'h1234, 16'h1234);
        cyc(0, 0, 16'h1234, 16'h1234);
        // Lock and check together while unlocked: lock wins.
        cyc(1, 1, 16'h1234, 16'h1234);
        cyc(0, 0, 16'h1234, 16'h1234);
        // Lock and check together while locked: check alone acts.
        cyc(1, 1, 16'h1234, 16'h1234);
        cyc(0, 0, 16'h1234, 16'h1234);
        // Into lockout, then reset three cycles in.
        cyc(1, 0, 16'h0001, 16'h0000);
        cyc(0, 0, 16'h0001, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 16'h0001, 16'h0000);
            cyc(0, 0, 16'h0001, 16'h0000);
        end
        cyc(0, 0, 16'h0001, 16'h0000);
        mid_reset("reset_in_lockout");
        cyc(0, 0, 16'h0, 16'h0);
        cyc(0, 1, 16'h0, 16'h0);
        mid_reset("reset_mid_pulse");

        // Random traffic with frequent matches.
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 2))
                0: a = 16'h0000;
                1: a = 16'h1234;
                default: a = 16'(($urandom));
            endcase
            g = ($urandom_range(0, 1) == 1) ? a : 16'(($urandom));
            ck = ($urandom_range(0, 2) == 0);
            lk = ($urandom_range(0, 4) == 0);
            cyc(lk, ck, g, a);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
